div_clk_meter: RTL and testbench
================================

# div_clk_meter

Measures a divided clock produced elsewhere in the design and reports its high time, low time and period in `clk` cycles. It is the checking end of the clock-divider path: the divider output, or any slow periodic strobe, enters `sig_in`, gets synchronized, and is timed edge to edge. Results are published once per period with a one-cycle `meas_valid` strobe. A stuck or absent input raises a timeout.

## Interface
- `CNT_W`, 16: width of the phase counters. The longest measurable phase is 2^CNT_W−1 cycles.
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in`. Legal range is 2 or more.
- `clk` input 1: the only clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sig_in` input 1: signal under measurement. It is asynchronous to `clk`.
- `high_cnt` output CNT_W: cycles the synchronized input was high in the last complete period.
- `low_cnt` output CNT_W: cycles it was low in the last complete period.
- `period` output CNT_W+1: `high_cnt + low_cnt`, computed at full width with no truncation.
- `odd` output 1: `period[0]`, registered with the other results.
- `balanced` output 1: 1 when |`high_cnt` − `low_cnt`| ≤ 1, registered.
- `meas_valid` output 1: one-cycle pulse when new results load.
- `timeout` output 1: one-cycle pulse when a phase exceeds counter range.

## Operation
- **Synchronizer:** `sig_in` passes through a SYNC_STAGES flop chain to give `s`. One more flop gives `s_d`.
  - `rise` = `s & ~s_d`; `fall` = `~s & s_d`.
  - Both edges have identical latency, so measured counts are exact in `clk` cycles.
- **States:** IDLE, MEAS_HIGH, MEAS_LOW. Reset state is IDLE.
- **Phase counter** `cnt` (CNT_W bits, internal): every cycle with no edge, `cnt <= cnt+1`.
- **IDLE**
  - `rise` → `cnt <= 1`, go to MEAS_HIGH.
  - `fall` and levels are ignored. A partial first phase is never reported.
- **MEAS_HIGH**
  - `fall` → `hi_lat <= cnt`, `cnt <= 1`, go to MEAS_LOW.
- **MEAS_LOW**
  - `rise` → load the outputs: `high_cnt <= hi_lat`, `low_cnt <= cnt`, `period <= hi_lat + cnt` (CNT_W+1 bits).
  - Also load `odd` and `balanced`, and pulse `meas_valid`.
  - Then `cnt <= 1` and go to MEAS_HIGH. Measurement is continuous with no gap cycle.
- **Timeout**
  - In MEAS_HIGH or MEAS_LOW: `cnt == 2^CNT_W−1` and no edge this cycle → pulse `timeout`, go to IDLE, discard `hi_lat`.
  - An edge arriving in the same cycle that `cnt` is at max is a normal event. The count max is reported.
- **Output holding:** result outputs hold their last values until the next `meas_valid`. A timeout does not clear them.
- **Balanced flag:** computed from the values being loaded, using an unsigned difference at CNT_W+1 bits.
- **Input limits:** pulses shorter than one `clk` period may be missed. This is out of spec.
  - The minimum legal phase is 1 cycle, which gives `period` = 2.

## Timing
- **Reset:** one `rst` cycle returns to IDLE. All outputs read 0, including `meas_valid` and `timeout`. The `cnt`, `hi_lat` and synchronizer flops are all cleared.
  - Reset mid-measurement abandons the period in progress. No valid pulse occurs for it.
  - After reset, the first report needs: one `rise` (after the synchronizer refills), a full high phase, a full low phase, and the next `rise`.
- **Latency:** a `sig_in` edge sampled at clock edge t is seen as `rise`/`fall` in the cycle after edge t+SYNC_STAGES−1. Outputs update on that cycle's closing edge.
  - `meas_valid` is high in the following cycle for exactly one cycle.
- **Steady state:** one `meas_valid` per input period, spaced exactly `period` cycles apart.
- **Exclusivity:** `meas_valid` and `timeout` are never high in the same cycle. `rise` and `fall` are mutually exclusive by construction.

## Test plan
- **Reset values:** hold `rst` 3 cycles with `sig_in` toggling → all outputs 0. No `meas_valid` until one full period after the first post-reset `rise`.
- **Odd period:** `sig_in` repeats 3 cycles high / 4 low, phase-aligned to `clk` → from the 2nd rising edge on: `high_cnt`=3, `low_cnt`=4, `period`=7, `odd`=1, `balanced`=1. `meas_valid` every 7 cycles.
- **Fastest input:** `sig_in` toggles every cycle → `high_cnt`=1, `low_cnt`=1, `period`=2, `odd`=0, `balanced`=1. `meas_valid` every 2 cycles.
- **Large odd divide:** divide-by-56818 waveform, 28409 high / 28409 low, with CNT_W=16 → `period`=56818, `odd`=0, `balanced`=1. Then switch to 28409/28410 → `period`=56819, `odd`=1, `balanced`=1. Separately, 20/5 → `balanced`=0.
- **Timeout:** CNT_W=4, `sig_in` held high 40 cycles after a `rise` → `timeout` pulses once, 15 cycles after the `rise` is detected. No `meas_valid`, prior outputs unchanged. Resuming 2/3 toggling gives normal reports.
- **Reset mid-measurement:** assert `rst` during the low phase of the 3/4 pattern → no `meas_valid` for the interrupted period, outputs read 0. The next report again gives 3/4/7.

Source files
------------

// File: rtl/div_clk_meter.sv
// -----------------------------------------------------------------------------
// div_clk_meter
//
// Times a slow periodic signal (typically a divided clock) in clk cycles.
// The input is synchronized, its edges are detected, and the high and low
// phase lengths of each complete period are published together with the
// period, an odd-period flag and a duty-balance flag. A phase that outruns
// the counter range raises a one-cycle timeout and the meter re-arms.
//
// Ports
//   clk         the only clock, rising edge
//   rst         synchronous, active-high reset
//   sig_in      signal under measurement, asynchronous to clk
//   high_cnt    high-phase length of the last complete period
//   low_cnt     low-phase length of the last complete period
//   period      high_cnt + low_cnt at full width
//   odd         period[0]
//   balanced    |high_cnt - low_cnt| <= 1
//   meas_valid  one-cycle pulse when the result outputs load
//   timeout     one-cycle pulse when a phase exceeds 2^CNT_W-1 cycles
// -----------------------------------------------------------------------------
module div_clk_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             odd,
    output logic             balanced,
    output logic             meas_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------------------------------------------------------------
    // Synchronizer and edge detect. s and s_d come from the same chain, so
    // rising and falling edges see identical latency and the phase counts
    // are exact.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;

    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge value of its neighbours; = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_lat;
    logic             cnt_at_max;
    logic             restart;
    logic             load_hi;
    logic             load_out;
    logic             to_evt;

    assign cnt_at_max = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        load_hi  = 1'b0;
        load_out = 1'b0;
        to_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a rising edge arms the meter; a partial first phase
                // is never reported.
                if (rise) begin
                    restart = 1'b1;
                    state_d = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    load_hi = 1'b1;
                    restart = 1'b1;
                    state_d = MEAS_LOW;
                end else if (cnt_at_max) begin
                    to_evt  = 1'b1;
                    state_d = IDLE;
                end
            end
            MEAS_LOW: begin
                // Closing rise also opens the next high phase: no gap cycle.
                if (rise) begin
                    load_out = 1'b1;
                    restart  = 1'b1;
                    state_d  = MEAS_HIGH;
                end else if (cnt_at_max) begin
                    to_evt  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Phase counter and high-phase latch. The edge cycle itself counts as
    // the first cycle of the new phase, hence the restart value of 1.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CNT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || to_evt) begin
            hi_lat <= '0;
        end else if (load_hi) begin
            hi_lat <= cnt;
        end
    end

    // ---------------------------------------------------------------------
    // Result computation, one bit wider than the counters so neither the
    // sum nor the difference can wrap.
    // ---------------------------------------------------------------------
    logic [CNT_W:0] sum_new;
    logic [CNT_W:0] diff_new;

    assign sum_new  = {1'b0, hi_lat} + {1'b0, cnt};
    assign diff_new = (hi_lat >= cnt) ? ({1'b0, hi_lat} - {1'b0, cnt})
                                      : ({1'b0, cnt} - {1'b0, hi_lat});

    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            odd        <= 1'b0;
            balanced   <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= load_out;
            timeout    <= to_evt;
            // Results hold across timeouts until the next complete period.
            if (load_out) begin
                high_cnt <= hi_lat;
                low_cnt  <= cnt;
                period   <= sum_new;
                odd      <= sum_new[0];
                balanced <= (diff_new <= (CNT_W+1)'(1));
            end
        end
    end

endmodule

// File: tb/tb_div_clk_meter.sv
// -----------------------------------------------------------------------------
// tb_div_clk_meter
//
// Three meters watch driven waveforms: u_a (16-bit counters, sig_a),
// u_b (16-bit counters, sig_b) and u_t (4-bit counters, sig_a). Each is
// compared every cycle against a timestamp-based reference model that
// measures phase lengths as differences between edge times of the
// synchronized input, plus directed checks against known constants.
// -----------------------------------------------------------------------------
module tb_div_clk_meter;

    localparam int SYNC   = 2;
    localparam int MAX16  = 65535;
    localparam int MAX4   = 15;

    logic clk;
    logic rst;
    logic sig_a;
    logic sig_b;

    logic [15:0] a_high, a_low, b_high, b_low;
    logic [16:0] a_period, b_period;
    logic [3:0]  t_high, t_low;
    logic [4:0]  t_period;
    logic        a_odd, a_bal, a_valid, a_to;
    logic        b_odd, b_bal, b_valid, b_to;
    logic        t_odd, t_bal, t_valid, t_to;

    div_clk_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) u_a (
        .clk(clk), .rst(rst), .sig_in(sig_a),
        .high_cnt(a_high), .low_cnt(a_low), .period(a_period),
        .odd(a_odd), .balanced(a_bal), .meas_valid(a_valid), .timeout(a_to)
    );

    div_clk_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) u_b (
        .clk(clk), .rst(rst), .sig_in(sig_b),
        .high_cnt(b_high), .low_cnt(b_low), .period(b_period),
        .odd(b_odd), .balanced(b_bal), .meas_valid(b_valid), .timeout(b_to)
    );

    div_clk_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) u_t (
        .clk(clk), .rst(rst), .sig_in(sig_a),
        .high_cnt(t_high), .low_cnt(t_low), .period(t_period),
        .odd(t_odd), .balanced(t_bal), .meas_valid(t_valid), .timeout(t_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: the synchronized level is the input delayed by SYNC
    // samples. Phase lengths are differences of edge timestamps; a report
    // is emitted at each rising edge that closes a high+low pair, and a
    // phase reaching max_len cycles without an edge is a timeout.
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [SYNC:0] sh;
        bit            armed;
        bit            in_high;
        int            cyc;
        int            start;
        int            hi_len;
        int            high_cnt;
        int            low_cnt;
        int            period;
        bit            odd;
        bit            bal;
        bit            valid;
        bit            to;
    } model_t;

    function automatic model_t model_step(model_t m, int max_len, bit r, bit din);
        model_t n;
        bit     cur;
        bit     prev;
        int     len;
        int     diff;
        n       = m;
        n.valid = 1'b0;
        n.to    = 1'b0;
        if (r) begin
            n = '0;
            return n;
        end
        cur  = m.sh[SYNC-1];
        prev = m.sh[SYNC];
        len  = m.cyc - m.start;
        if (!m.armed) begin
            if (cur && !prev) begin
                n.armed   = 1'b1;
                n.in_high = 1'b1;
                n.start   = m.cyc;
            end
        end else if (m.in_high && !cur && prev) begin
            n.hi_len  = len;
            n.start   = m.cyc;
            n.in_high = 1'b0;
        end else if (!m.in_high && cur && !prev) begin
            n.high_cnt = m.hi_len;
            n.low_cnt  = len;
            n.period   = m.hi_len + len;
            n.odd      = (n.period % 2) == 1;
            diff       = (m.hi_len > len) ? m.hi_len - len : len - m.hi_len;
            n.bal      = (diff <= 1);
            n.valid    = 1'b1;
            n.start    = m.cyc;
            n.in_high  = 1'b1;
        end else if (len == max_len) begin
            n.to    = 1'b1;
            n.armed = 1'b0;
        end
        n.sh  = {m.sh[SYNC-1:0], din};
        n.cyc = m.cyc + 1;
        return n;
    endfunction

    model_t ma, mb, mt;

    always @(posedge clk) begin
        ma = model_step(ma, MAX16, rst, sig_a);
        mb = model_step(mb, MAX16, rst, sig_b);
        mt = model_step(mt, MAX4,  rst, sig_a);
    end

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int last_v = 0;
    int prev_v = 0;
    int t_to_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a.high",   32'(a_high),   32'(ma.high_cnt));
        check("a.low",    32'(a_low),    32'(ma.low_cnt));
        check("a.period", 32'(a_period), 32'(ma.period));
        check("a.odd",    32'(a_odd),    32'(ma.odd));
        check("a.bal",    32'(a_bal),    32'(ma.bal));
        check("a.valid",  32'(a_valid),  32'(ma.valid));
        check("a.to",     32'(a_to),     32'(ma.to));
        check("b.high",   32'(b_high),   32'(mb.high_cnt));
        check("b.low",    32'(b_low),    32'(mb.low_cnt));
        check("b.period", 32'(b_period), 32'(mb.period));
        check("b.odd",    32'(b_odd),    32'(mb.odd));
        check("b.bal",    32'(b_bal),    32'(mb.bal));
        check("b.valid",  32'(b_valid),  32'(mb.valid));
        check("b.to",     32'(b_to),     32'(mb.to));
        check("t.high",   32'(t_high),   32'(mt.high_cnt));
        check("t.low",    32'(t_low),    32'(mt.low_cnt));
        check("t.period", 32'(t_period), 32'(mt.period));
        check("t.odd",    32'(t_odd),    32'(mt.odd));
        check("t.bal",    32'(t_bal),    32'(mt.bal));
        check("t.valid",  32'(t_valid),  32'(mt.valid));
        check("t.to",     32'(t_to),     32'(mt.to));
        check("t.excl",   32'(t_valid & t_to), 32'd0);
    endtask

    // One clock: check the state left by the previous edge, then drive.
    task automatic tick(input bit a, input bit b);
        @(negedge clk);
        compare_all();
        cyc_n++;
        if (a_valid) begin
            prev_v = last_v;
            last_v = cyc_n;
        end
        if (t_to) t_to_cnt++;
        sig_a = a;
        sig_b = b;
    endtask

    task automatic phase(input bit lvl, input int n);
        for (int i = 0; i < n; i++) tick(lvl, lvl);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        rst   = 1'b1;
        sig_a = 1'b0;
        sig_b = 1'b0;

        // Reset held 3 cycles with the input toggling.
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        check("rst.high",   32'(a_high),   32'd0);
        check("rst.period", 32'(a_period), 32'd0);
        check("rst.valid",  32'(a_valid),  32'd0);
        check("rst.to",     32'(t_to),     32'd0);
        rst = 1'b0;
        phase(1'b0, 4);

        // Odd period: 3 high / 4 low.
        for (int k = 0; k < 6; k++) begin
            phase(1'b1, 3);
            phase(1'b0, 4);
        end
        check("odd.high",    32'(a_high),   32'd3);
        check("odd.low",     32'(a_low),    32'd4);
        check("odd.period",  32'(a_period), 32'd7);
        check("odd.odd",     32'(a_odd),    32'd1);
        check("odd.bal",     32'(a_bal),    32'd1);
        check("odd.spacing", 32'(last_v - prev_v), 32'd7);

        // Fastest input: toggle every cycle.
        for (int k = 0; k < 8; k++) begin
            phase(1'b1, 1);
            phase(1'b0, 1);
        end
        phase(1'b0, 3);
        check("fast.high",    32'(a_high),   32'd1);
        check("fast.low",     32'(a_low),    32'd1);
        check("fast.period",  32'(a_period), 32'd2);
        check("fast.odd",     32'(a_odd),    32'd0);
        check("fast.bal",     32'(a_bal),    32'd1);
        check("fast.spacing", 32'(last_v - prev_v), 32'd2);

        // Timeout on the 4-bit meter: 2/3 toggling, then 40 cycles high.
        for (int k = 0; k < 3; k++) begin
            phase(1'b1, 2);
            phase(1'b0, 3);
        end
        t_to_cnt = 0;
        phase(1'b1, 40);
        check("to.count",  32'(t_to_cnt), 32'd1);
        check("to.hold_h", 32'(t_high),   32'd2);
        check("to.hold_p", 32'(t_period), 32'd5);
        phase(1'b0, 3);
        for (int k = 0; k < 3; k++) begin
            phase(1'b1, 2);
            phase(1'b0, 3);
        end
        check("to.resume_h", 32'(t_high),   32'd2);
        check("to.resume_l", 32'(t_low),    32'd3);
        check("to.resume_p", 32'(t_period), 32'd5);

        // Reset in the low phase of a 3/4 pattern.
        for (int k = 0; k < 3; k++) begin
            phase(1'b1, 3);
            phase(1'b0, 4);
        end
        phase(1'b1, 3);
        phase(1'b0, 2);
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        check("rmid.high",   32'(a_high),   32'd0);
        check("rmid.period", 32'(a_period), 32'd0);
        phase(1'b0, 2);
        for (int k = 0; k < 3; k++) begin
            phase(1'b1, 3);
            phase(1'b0, 4);
        end
        check("rmid.high2",   32'(a_high),   32'd3);
        check("rmid.low2",    32'(a_low),    32'd4);
        check("rmid.period2", 32'(a_period), 32'd7);

        // Unbalanced 20/5.
        for (int k = 0; k < 2; k++) begin
            phase(1'b1, 20);
            phase(1'b0, 5);
        end
        phase(1'b1, 4);
        check("unbal.period", 32'(a_period), 32'd25);
        check("unbal.odd",    32'(a_odd),    32'd1);
        check("unbal.bal",    32'(a_bal),    32'd0);

        // Random phases, some long enough to time out the 4-bit meter.
        phase(1'b0, 3);
        for (int k = 0; k < 200; k++) begin
            phase(1'b1, int'($urandom_range(1, 24)));
            phase(1'b0, int'($urandom_range(1, 24)));
        end

        // Large divide: u_a sees 28409/28409, u_b sees 28409/28410.
        phase(1'b0, 5);
        for (int i = 0; i < 56830; i++) begin
            tick(i < 28409 || i >= 56818, i < 28409 || i >= 56819);
        end
        check("big.a_high",   32'(a_high),   32'd28409);
        check("big.a_period", 32'(a_period), 32'd56818);
        check("big.a_odd",    32'(a_odd),    32'd0);
        check("big.a_bal",    32'(a_bal),    32'd1);
        check("big.b_low",    32'(b_low),    32'd28410);
        check("big.b_period", 32'(b_period), 32'd56819);
        check("big.b_odd",    32'(b_odd),    32'd1);
        check("big.b_bal",    32'(b_bal),    32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
